// File: rtl/sub_issue_stage.sv
// Operand-issue / result-capture stage around an external combinational 16-bit subtracter.
// Stage 1 holds operands on the subtracter inputs; stage 2 is a 2-entry result FIFO with flags.
module sub_issue_stage (
  input  logic        iClk,
  input  logic        iRstn,
  input  logic        iValid,
  output logic        oReady,
  input  logic [15:0] iA,
  input  logic [15:0] iB,
  input  logic        iC,
  output logic [15:0] oSubA,
  output logic [15:0] oSubB,
  output logic        oSubC,
  input  logic [15:0] iSubDiff,
  output logic        oValid,
  input  logic        iReady,
  output logic [15:0] oDiff,
  output logic        oBorrow,
  output logic        oZero,
  output logic        oNeg,
  output logic        oOvf,
  output logic        oMismatch
);

  // FIFO entry layout: {diff[15:0], borrow, zero, neg, ovf}
  logic        s1Valid_q, s1Valid_d;
  logic [15:0] s1A_q, s1A_d;
  logic [15:0] s1B_q, s1B_d;
  logic        s1C_q, s1C_d;
  logic [19:0] fifoMem_q [2];
  logic [19:0] fifoMem_d [2];
  logic        wrPtr_q, wrPtr_d;
  logic        rdPtr_q, rdPtr_d;
  logic [1:0]  count_q, count_d;
  logic        mismatch_q, mismatch_d;

  logic        fifoRead;
  logic        fifoFull;
  logic        fifoWrite;
  logic        s1Load;
  logic [15:0] refDiff;
  logic        wrBorrow;
  logic        wrZero;
  logic        wrNeg;
  logic        wrOvf;
  logic [19:0] headEntry;

  // A read in the same cycle frees a slot, so a full FIFO can still take a write.
  always_comb begin
    fifoRead  = (count_q != 2'd0) && iReady;
    fifoFull  = (count_q == 2'd2) && !fifoRead;
    fifoWrite = s1Valid_q && !fifoFull;
    oReady    = !s1Valid_q || !fifoFull;
    s1Load    = iValid && oReady;

    refDiff  = s1A_q - s1B_q - {15'b0, s1C_q};
    wrBorrow = ({1'b0, s1A_q} < ({1'b0, s1B_q} + {16'b0, s1C_q}));
    wrZero   = (iSubDiff == 16'h0000);
    wrNeg    = iSubDiff[15];
    wrOvf    = (s1A_q[15] ^ s1B_q[15]) & (s1A_q[15] ^ iSubDiff[15]);
  end

  always_comb begin
    s1Valid_d  = s1Valid_q;
    s1A_d      = s1A_q;
    s1B_d      = s1B_q;
    s1C_d      = s1C_q;
    fifoMem_d  = fifoMem_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    mismatch_d = mismatch_q;

    if (s1Load) begin
      s1Valid_d = 1'b1;
      s1A_d     = iA;
      s1B_d     = iB;
      s1C_d     = iC;
    end else if (fifoWrite) begin
      s1Valid_d = 1'b0;
    end

    if (fifoWrite) begin
      fifoMem_d[wrPtr_q] = {iSubDiff, wrBorrow, wrZero, wrNeg, wrOvf};
      wrPtr_d            = wrPtr_q + 1'b1;
      if (iSubDiff != refDiff) mismatch_d = 1'b1;
    end

    if (fifoRead) rdPtr_d = rdPtr_q + 1'b1;

    case ({fifoWrite, fifoRead})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      s1Valid_q    <= 1'b0;
      s1A_q        <= 16'h0000;
      s1B_q        <= 16'h0000;
      s1C_q        <= 1'b0;
      fifoMem_q[0] <= 20'h00000;
      fifoMem_q[1] <= 20'h00000;
      wrPtr_q      <= 1'b0;
      rdPtr_q      <= 1'b0;
      count_q      <= 2'd0;
      mismatch_q   <= 1'b0;
    end else begin
      s1Valid_q    <= s1Valid_d;
      s1A_q        <= s1A_d;
      s1B_q        <= s1B_d;
      s1C_q        <= s1C_d;
      fifoMem_q[0] <= fifoMem_d[0];
      fifoMem_q[1] <= fifoMem_d[1];
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      count_q      <= count_d;
      mismatch_q   <= mismatch_d;
    end
  end

  always_comb begin
    headEntry = fifoMem_q[rdPtr_q];
    oSubA     = s1A_q;
    oSubB     = s1B_q;
    oSubC     = s1C_q;
    oValid    = (count_q != 2'd0);
    oDiff     = headEntry[19:4];
    oBorrow   = headEntry[3];
    oZero     = headEntry[2];
    oNeg      = headEntry[1];
    oOvf      = headEntry[0];
    oMismatch = mismatch_q;
  end

endmodule
